pipeline_control_unit: RTL and testbench
========================================

// Module: pipeline_control_unit
// PURPOSE
//  Central sequencer for the 5-stage pipeline: owns PC and IF/ID, ID/EX, EX/MEM, MEM/WB latch enables/flushes.
//  Merges hazard-unit load-use requests, EX-stage redirects, i/d-memory waits and halt into one prioritized decision per cycle.
//  Tracks halt drain, keeps performance counters and runs a d-memory watchdog. Sits beside hazard_unit in the datapath top.
// PARAMETERS
//  CNT_W     32    width of stall_cnt / flush_cnt (saturating)
//  WD_LIMIT  1024  consecutive DWAIT cycles before mem_timeout; 0 disables watchdog
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      asynchronous, active-high reset
//  ihit         in   1      instruction fetch complete this cycle
//  dhit         in   1      data access complete this cycle
//  mem_dREN     in   1      MEM-stage load request
//  mem_dWEN     in   1      MEM-stage store request
//  hu_dx_flush  in   1      load-use hazard from hazard_unit (dx_flush)
//  ex_redirect  in   1      taken branch or jump resolved in EX
//  id_halt      in   1      HALT decoded in ID
//  wb_halt      in   1      HALT reached WB
//  pc_en        out  1      PC update enable
//  pc_redirect  out  1      PC source = EX target (else PC+4)
//  fd_en/fd_flush, dx_en/dx_flush, xm_en/xm_flush, mw_en/mw_flush  out 1 each  latch enable / bubble insert
//  halt         out  1      sticky processor halted
//  mem_timeout  out  1      sticky watchdog fire
//  stall_cnt    out  CNT_W  cycles with pc_en=0 in RUN/DWAIT
//  flush_cnt    out  CNT_W  redirects taken
// BEHAVIOUR
//  States (registered): RUN, DWAIT, HALTING, HALTED. Reset -> RUN, counters 0, halt=0, mem_timeout=0.
//  While RST high: all en/flush, pc_en, pc_redirect = 0. Decode is combinational from state + inputs.
//  Any xx_flush=1 implies xx_en=1 (bubble is a write).
//  Per-cycle priority in RUN/DWAIT/HALTING (first match wins):
//   1 dwait = (mem_dREN|mem_dWEN)&~dhit: pc_en=fd_en=dx_en=xm_en=0, mw_en=mw_flush=1; next DWAIT
//     (HALTING stays HALTING). Redirect/load-use/halt ignored; inputs persist because EX/ID hold.
//   2 ex_redirect: pc_en=pc_redirect=1, fd_flush=dx_flush=1, xm_en=mw_en=1; flush_cnt++.
//     HALTING -> RUN (halt was wrong-path); id_halt same cycle ignored.
//   3 hu_dx_flush: pc_en=0, fd_en=0, dx_flush=1, xm_en=mw_en=1.
//   4 ~ihit or state HALTING: pc_en=0, fd_flush=1, dx_en=xm_en=mw_en=1.
//   5 else all en=1, pc_en=1.
//  RUN/DWAIT + id_halt with rules 1-3 not matching -> HALTING (ID instr advances this cycle).
//  DWAIT returns to RUN when dwait clears (HALTING if id_halt accepted that cycle).
//  HALTING + wb_halt (any priority) -> HALTED. HALTED: all en/flush/pc_en = 0, halt=1 until RST.
//  stall_cnt: +1 when pc_en=0 and state in {RUN,DWAIT}; saturates at all-ones. flush_cnt saturates too.
//  Watchdog: wd_cnt clears on any non-dwait cycle, +1 per dwait cycle; wd_cnt==WD_LIMIT-1 with
//   dwait -> mem_timeout=1 sticky. No effect on pipeline.
//  RST mid-operation: immediate return to reset values; a pending DWAIT or HALTING is discarded.
// TESTING
//  T1 ihit=1,dhit=1, no hazards 10 cycles -> all en=1 every cycle, stall_cnt=0, flush_cnt=0.
//  T2 mem_dREN=1, dhit=0 for 3 cycles then 1 -> 3 cycles pc_en=0, mw_flush=1, state DWAIT;
//     cycle 4 all en=1; stall_cnt=3.
//  T3 hu_dx_flush=1 and ex_redirect=1 same cycle -> pc_redirect=1, fd_flush=dx_flush=1, fd_en=1; flush_cnt=1.
//  T4 id_halt pulse, then ex_redirect 1 cycle later -> state HALTING then RUN, pc_redirect=1, halt stays 0.
//  T5 id_halt, wb_halt 3 cycles later -> fd_flush=1 while HALTING; HALTED with halt=1,
//     all en=0; holds 20 cycles until RST.
//  T6 WD_LIMIT=4, dREN=1, dhit=0 for 6 cycles -> mem_timeout rises at 4th DWAIT cycle, stays after dhit.
//     Also sat check: CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// pipeline_control_unit
//
// Central sequencer for a 5-stage pipeline. Owns the PC enable/source and
// the enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Merges
// d-memory waits, EX redirects, load-use hazards, i-fetch misses and halt
// into one prioritized decision per cycle. Also tracks halt drain, keeps
// saturating stall/flush counters and runs a d-memory watchdog.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   ihit, dhit                    i-fetch / d-access complete this cycle
//   mem_dREN, mem_dWEN            MEM-stage load / store request
//   hu_dx_flush                   load-use hazard from hazard_unit
//   ex_redirect                   taken branch/jump resolved in EX
//   id_halt, wb_halt              HALT decoded in ID / reached WB
//   pc_en, pc_redirect            PC update enable / PC source = EX target
//   {fd,dx,xm,mw}_{en,flush}      latch enable / bubble insert
//   halt, mem_timeout             sticky halted / sticky watchdog fire
//   stall_cnt, flush_cnt          saturating performance counters
// ---------------------------------------------------------------------------
module pipeline_control_unit #(
    parameter int CNT_W    = 32,
    parameter int WD_LIMIT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             hu_dx_flush,
    input  logic             ex_redirect,
    input  logic             id_halt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             dx_en,
    output logic             dx_flush,
    output logic             xm_en,
    output logic             xm_flush,
    output logic             mw_en,
    output logic             mw_flush,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, DWAIT, HALTING, HALTED} state_t;

    state_t state_reg, state_next;
    logic   dwait;
    logic   dwait_active;
    logic   stall_inc;
    logic   flush_inc;

    assign dwait        = (mem_dREN | mem_dWEN) & ~dhit;
    assign dwait_active = dwait & (state_reg != HALTED);
    assign halt         = (state_reg == HALTED);

    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        fd_en       = 1'b0;
        fd_flush    = 1'b0;
        dx_en       = 1'b0;
        dx_flush    = 1'b0;
        xm_en       = 1'b0;
        xm_flush    = 1'b0;
        mw_en       = 1'b0;
        mw_flush    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_next  = state_reg;

        // Everything stays quiet while reset is held and once halted.
        if (!RST && state_reg != HALTED) begin
            if (dwait) begin
                // Freeze the front of the pipe, let WB drain a bubble.
                // Redirect/hazard/halt inputs are held by EX/ID and retried.
                mw_en    = 1'b1;
                mw_flush = 1'b1;
                if (state_reg != HALTING)
                    state_next = DWAIT;
            end else if (ex_redirect) begin
                // A redirect also cancels a pending halt: it was wrong-path.
                pc_en       = 1'b1;
                pc_redirect = 1'b1;
                fd_en       = 1'b1;
                fd_flush    = 1'b1;
                dx_en       = 1'b1;
                dx_flush    = 1'b1;
                xm_en       = 1'b1;
                mw_en       = 1'b1;
                flush_inc   = 1'b1;
                state_next  = RUN;
            end else if (hu_dx_flush) begin
                dx_en    = 1'b1;
                dx_flush = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
                if (state_reg != HALTING)
                    state_next = RUN;
            end else begin
                if (!ihit || state_reg == HALTING) begin
                    // No new fetch: feed a bubble into ID, back end keeps moving.
                    fd_en    = 1'b1;
                    fd_flush = 1'b1;
                    dx_en    = 1'b1;
                    xm_en    = 1'b1;
                    mw_en    = 1'b1;
                end else begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                    dx_en = 1'b1;
                    xm_en = 1'b1;
                    mw_en = 1'b1;
                end
                // The HALT in ID advances this cycle, so stop fetching after it.
                if (state_reg != HALTING)
                    state_next = id_halt ? HALTING : RUN;
            end

            if (state_reg == HALTING && wb_halt)
                state_next = HALTED;

            stall_inc = !pc_en && (state_reg != HALTING);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_reg <= state_next;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    generate
        if (WD_LIMIT > 0) begin : g_wd
            localparam int WD_W = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
            localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

            logic [WD_W-1:0] wd_cnt_reg;

            // wd_cnt_reg counts prior consecutive dwait cycles; it parks at
            // WD_LAST once reached so it cannot wrap during a long wait.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    wd_cnt_reg  <= '0;
                    mem_timeout <= 1'b0;
                end else if (dwait_active) begin
                    if (wd_cnt_reg == WD_LAST)
                        mem_timeout <= 1'b1;
                    else
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                end else begin
                    wd_cnt_reg <= '0;
                end
            end
        end else begin : g_no_wd
            assign mem_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control_unit
//
// Directed scenarios with literal expectations plus randomized episodes.
// A behavioural model (rule number -> latch-control table, integer counters,
// consecutive-wait count) is checked against the DUT on every falling edge.
// DUT built with CNT_W=4 and WD_LIMIT=4 so saturation and the watchdog
// are reachable in short runs.
// ---------------------------------------------------------------------------
module tb_pipeline_control_unit;

    localparam int CNT_W   = 4;
    localparam int WD      = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int M_RUN     = 0;
    localparam int M_DWAIT   = 1;
    localparam int M_HALTING = 2;
    localparam int M_HALTED  = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
    logic hu_dx_flush = 1'b0, ex_redirect = 1'b0, id_halt = 1'b0, wb_halt = 1'b0;
    logic pc_en, pc_redirect, fd_en, fd_flush, dx_en, dx_flush;
    logic xm_en, xm_flush, mw_en, mw_flush, halt, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_state = M_RUN;
    int m_stall = 0;
    int m_flush = 0;
    int m_wait_run = 0;
    bit m_to = 1'b0;

    pipeline_control_unit #(.CNT_W(CNT_W), .WD_LIMIT(WD)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .hu_dx_flush(hu_dx_flush), .ex_redirect(ex_redirect),
        .id_halt(id_halt), .wb_halt(wb_halt),
        .pc_en(pc_en), .pc_redirect(pc_redirect),
        .fd_en(fd_en), .fd_flush(fd_flush), .dx_en(dx_en), .dx_flush(dx_flush),
        .xm_en(xm_en), .xm_flush(xm_flush), .mw_en(mw_en), .mw_flush(mw_flush),
        .halt(halt), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Control vector order: pc_en pc_redirect fd_en fd_flush dx_en dx_flush
    //                       xm_en xm_flush mw_en mw_flush
    function automatic logic [9:0] rule_vec(input int rule);
        case (rule)
            1:       return 10'b00_00_00_00_11;  // d-mem wait
            2:       return 10'b11_11_11_10_10;  // EX redirect
            3:       return 10'b00_00_11_10_10;  // load-use
            4:       return 10'b00_11_10_10_10;  // fetch bubble / draining
            5:       return 10'b10_10_10_10_10;  // normal advance
            default: return 10'b00_00_00_00_00;  // halted / reset
        endcase
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Per-cycle compare against the model, then advance the model across
    // the coming rising edge (inputs are stable from here to that edge).
    always @(negedge CLK) begin
        int rule;
        bit dw;
        logic [9:0] exp_v;
        logic [9:0] act_v;
        act_v = {pc_en, pc_redirect, fd_en, fd_flush, dx_en, dx_flush,
                 xm_en, xm_flush, mw_en, mw_flush};
        if (RST) begin
            m_state = M_RUN; m_stall = 0; m_flush = 0; m_wait_run = 0; m_to = 1'b0;
            check("rst_ctrl", int'(act_v), 0);
            check("rst_cnt", int'({stall_cnt, flush_cnt}), 0);
            check("rst_flags", int'({halt, mem_timeout}), 0);
        end else begin
            dw = (mem_dREN | mem_dWEN) & ~dhit;
            if (m_state == M_HALTED)                      rule = 0;
            else if (dw)                                  rule = 1;
            else if (ex_redirect)                         rule = 2;
            else if (hu_dx_flush)                         rule = 3;
            else if (!ihit || m_state == M_HALTING)       rule = 4;
            else                                          rule = 5;
            exp_v = rule_vec(rule);

            check("ctrl_vec", int'(act_v), int'(exp_v));
            check("halt", int'(halt), (m_state == M_HALTED) ? 1 : 0);
            check("mem_timeout", int'(mem_timeout), int'(m_to));
            check("stall_cnt", int'(stall_cnt), m_stall);
            check("flush_cnt", int'(flush_cnt), m_flush);

            if (!exp_v[9] && (m_state == M_RUN || m_state == M_DWAIT))
                m_stall = imin(m_stall + 1, CNT_MAX);
            if (rule == 2)
                m_flush = imin(m_flush + 1, CNT_MAX);

            if (rule == 1) begin
                m_wait_run++;
                if (m_wait_run >= WD) m_to = 1'b1;
            end else begin
                m_wait_run = 0;
            end

            if (m_state != M_HALTED) begin
                if (m_state == M_HALTING && wb_halt)
                    m_state = M_HALTED;
                else if (rule == 1)
                    m_state = (m_state == M_HALTING) ? M_HALTING : M_DWAIT;
                else if (rule == 2)
                    m_state = M_RUN;
                else if (rule == 3)
                    m_state = (m_state == M_HALTING) ? M_HALTING : M_RUN;
                else if (m_state != M_HALTING)
                    m_state = id_halt ? M_HALTING : M_RUN;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        hu_dx_flush = 1'b0; ex_redirect = 1'b0; id_halt = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        step();
        RST = 1'b0;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        step();
        step();
        check("T0_pc_en_in_reset", int'(pc_en), 0);
        check("T0_halt_in_reset", int'(halt), 0);
        RST = 1'b0;

        // T1: free running
        repeat (10) begin
            #1;
            check("T1_all_en", int'({pc_en, fd_en, dx_en, xm_en, mw_en}), 5'b11111);
            step();
        end
        check("T1_stall_cnt", int'(stall_cnt), 0);
        check("T1_flush_cnt", int'(flush_cnt), 0);

        // T2: three cycles of load wait
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0;
        repeat (3) begin
            #1;
            check("T2_wait_ctrl", int'({pc_en, mw_flush}), 2'b01);
            step();
        end
        dhit = 1'b1;
        #1;
        check("T2_resume_en", int'({pc_en, fd_en, dx_en, xm_en, mw_en}), 5'b11111);
        step();
        mem_dREN = 1'b0;
        check("T2_stall_cnt", int'(stall_cnt), 3);

        // T3: redirect beats load-use
        do_reset();
        hu_dx_flush = 1'b1; ex_redirect = 1'b1;
        #1;
        check("T3_ctrl", int'({pc_redirect, fd_en, fd_flush, dx_flush}), 4'b1111);
        step();
        hu_dx_flush = 1'b0; ex_redirect = 1'b0;
        check("T3_flush_cnt", int'(flush_cnt), 1);

        // T4: halt cancelled by a later redirect
        do_reset();
        id_halt = 1'b1;
        step();
        id_halt = 1'b0; ex_redirect = 1'b1;
        #1;
        check("T4_redirect", int'({pc_en, pc_redirect}), 2'b11);
        step();
        ex_redirect = 1'b0;
        #1;
        check("T4_back_in_run", int'(pc_en), 1);
        check("T4_halt", int'(halt), 0);

        // T5: halt drains and sticks
        do_reset();
        id_halt = 1'b1;
        step();
        id_halt = 1'b0;
        repeat (2) begin
            #1;
            check("T5_draining", int'({pc_en, fd_flush}), 2'b01);
            step();
        end
        wb_halt = 1'b1;
        step();
        wb_halt = 1'b0;
        repeat (20) begin
            check("T5_halted", int'({halt, pc_en, fd_en, mw_en}), 4'b1000);
            step();
        end

        // T6: watchdog at 4th consecutive wait cycle, sticky afterwards
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("T6_timeout", int'(mem_timeout), (k >= WD) ? 1 : 0);
        end
        dhit = 1'b1;
        step();
        mem_dREN = 1'b0;
        step();
        check("T6_sticky", int'(mem_timeout), 1);

        // Counter saturation
        do_reset();
        ihit = 1'b0;
        repeat (20) step();
        check("SAT_stall_cnt", int'(stall_cnt), 15);
        ihit = 1'b1; ex_redirect = 1'b1;
        repeat (20) step();
        ex_redirect = 1'b0;
        check("SAT_flush_cnt", int'(flush_cnt), 15);

        // Randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            int dhit_pct;
            do_reset();
            dhit_pct = int'($urandom_range(20, 90));
            for (int c = 0; c < 100; c++) begin
                RST         = ($urandom_range(0, 99) < 2);
                ihit        = ($urandom_range(0, 99) < 80);
                dhit        = ($urandom_range(0, 99) < dhit_pct);
                mem_dREN    = ($urandom_range(0, 99) < 25);
                mem_dWEN    = ($urandom_range(0, 99) < 12);
                hu_dx_flush = ($urandom_range(0, 99) < 15);
                ex_redirect = ($urandom_range(0, 99) < 10);
                id_halt     = ($urandom_range(0, 99) < 6);
                wb_halt     = ($urandom_range(0, 99) < 20);
                step();
            end
        end
        RST = 1'b0;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
